instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the CPU core. Owns the program counter and drives the program memory address. Captures each returned 16-bit instruction into a 2-entry prefetch queue and presents it to decode with a valid/ready handshake. Accepts branch/jump redirects from downstream, which flush the queue and restart fetch at a new address.

## Interface

Parameters:
- ADDR_WIDTH, 6, program counter / program memory address width; PC range 0 .. 2^ADDR_WIDTH-1

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- pm_addr  output  ADDR_WIDTH  address to program memory; combinationally equal to the PC register
- pm_data  input  16  instruction word from program memory; combinational response to pm_addr in the same cycle
- instr  output  16  instruction at the queue head; 16'h0000 when the queue is empty
- instr_pc  output  ADDR_WIDTH  address of `instr`; 0 when the queue is empty
- instr_valid  output  1  queue non-empty
- instr_ready  input  1  decode accepts the head this cycle
- redirect  input  1  taken branch or jump
- redirect_addr  input  ADDR_WIDTH  new PC; already resolved by downstream, absolute value
- halted  output  1  fetch stopped on a zero word (see Configuration)

## Operation

State:
- PC register
- 2-entry FIFO of {instr, pc}
- count 0..2
- halted flag

Per-cycle priority, evaluated at each rising edge:
1. **rst**
   - PC=0, queue emptied, halted=0.
   - Every other input is ignored.
2. **redirect**
   - Queue flushed. A handshake in the same cycle is discarded.
   - PC=redirect_addr, halted=0.
   - No fetch is enqueued this cycle.
3. **Otherwise**
   - Pop: occurs when instr_valid && instr_ready.
   - Fetch: occurs when !halted && (count<2 || pop).
   - A fetch enqueues {pm_data, PC} and sets PC to PC+1 modulo 2^ADDR_WIDTH.
   - Pop and fetch may occur in the same cycle; count is unchanged.

Queue and PC rules:
- FIFO order is strict. No instruction is dropped or duplicated except by a flush.
- PC wraps 2^ADDR_WIDTH-1 → 0 with no flag.
- Full queue with no pop: PC and pm_addr hold, and the head is stable.
- instr and instr_pc are stable while instr_valid && !instr_ready, unless rst or redirect occurs.

## Timing

- Reset values:
  - pm_addr=0, instr=16'h0000, instr_pc=0, instr_valid=0, halted=0.
- After reset:
  - First edge with rst low enqueues PC 0.
  - instr_valid rises after that edge.
- Fetch-to-decode latency:
  - 1 cycle: the word addressed in cycle N is at the head in cycle N+1 when the queue was empty.
- Throughput:
  - 1 instruction/cycle with instr_ready held high.
- Redirect sampled at edge N:
  - instr_valid=0 in cycle N+1.
  - redirect_addr is fetched in cycle N+1.
  - redirect_addr is presented in cycle N+2.
  - Redirect penalty: 1 bubble.
- Back-to-back redirects:
  - The last one wins.
  - No instruction is delivered between them.
- Simultaneous events:
  - rst together with redirect: reset wins.
  - redirect together with a handshake: the handshake is ignored.

## Configuration

FETCH_HALT_ON_ZERO_EN:
- **Defined:**
  - A fetched word equal to 16'h0000 is not enqueued.
  - halted=1 from the next cycle, and PC holds at the zero word's address.
  - Instructions already queued still drain normally.
  - redirect clears halted and resumes fetch.
  - Zero words are unused program memory fill.
- **Undefined:**
  - 16'h0000 is fetched and delivered like any other word (decodes as ADDI R0,R0,#0).
  - halted is tied to 0.

## Test plan

1. **Sequential fetch**
   - Stimulus: program memory words 0..5 distinct; release rst; hold instr_ready=1.
   - Required: instr_valid rises one cycle after rst falls; instr_pc=0,1,2,3 on consecutive cycles; instr matches the memory word at each address.
2. **Backpressure**
   - Stimulus: instr_ready=0 for 5 cycles after the first valid, then 1.
   - Required: count reaches 2; pm_addr holds at 2; head stays PC 0 with stable instr; after release, instr_pc=0,1,2,3 with no gap and no duplicate.
3. **Redirect flush**
   - Stimulus: with the queue holding PCs 4 and 5, pulse redirect with redirect_addr=30 for 1 cycle.
   - Required: instr_valid=0 for the next cycle; then instr_pc=30,31; PCs 4 and 5 are never accepted.
4. **Wrap-around**
   - Stimulus: redirect to 63 with instr_ready=1.
   - Required: instr_pc=63 then 0 then 1.
5. **Halt on zero word**
   - Stimulus: word 40 = 16'h0000; redirect to 38.
   - Required with FETCH_HALT_ON_ZERO_EN: instr_pc=38,39 delivered; halted=1; pm_addr stays 40; no further valid. Redirect to 30 clears halted and delivers PC 30.
   - Required without the macro: PC 40 is delivered with instr=16'h0000; halted stays 0.
6. **Reset priority**
   - Stimulus: full queue with rst=1 and redirect=1 in the same cycle.
   - Required: next cycle instr_valid=0, pm_addr=0, halted=0; fetch restarts at PC 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program memory port, decode handshake, and redirect input.
// The master modport is the fetch unit; the slave modport is memory/decode/branch logic.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] pm_addr;
    logic [15:0]           pm_data;
    logic [15:0]           instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  halted;

    modport master (
        output pm_addr, instr, instr_pc, instr_valid, halted,
        input  pm_data, instr_ready, redirect, redirect_addr
    );

    modport slave (
        input  pm_addr, instr, instr_pc, instr_valid, halted,
        output pm_data, instr_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, 2-entry prefetch queue of {instr, pc}, and redirect flush.
// Optional FETCH_HALT_ON_ZERO_EN stops fetch on a 16'h0000 word until the next redirect.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    addr_t       pc_q, pc_d;
    logic [15:0] q_instr_q [2];
    logic [15:0] q_instr_d [2];
    addr_t       q_pc_q [2];
    addr_t       q_pc_d [2];
    logic [1:0]  count_q, count_d;
    logic        halted_q, halted_d;

    logic pop, fetch, enq, zero_word, wr_slot;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign zero_word = (bus.pm_data == 16'h0000);
`else
    assign zero_word = 1'b0;
`endif

    always_comb begin
        pop       = (count_q != 2'd0) && bus.instr_ready;
        fetch     = !halted_q && ((count_q != 2'd2) || pop);
        enq       = fetch && !zero_word;
        // Slot 0 is always the head; a pop shifts slot 1 down before the write lands.
        wr_slot   = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

        pc_d      = pc_q;
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        count_d   = count_q;
        halted_d  = halted_q;

        if (bus.redirect) begin
            pc_d     = bus.redirect_addr;
            count_d  = 2'd0;
            halted_d = 1'b0;
        end else begin
            if (fetch && zero_word) begin
                halted_d = 1'b1;
            end
            if (pop) begin
                q_instr_d[0] = q_instr_q[1];
                q_pc_d[0]    = q_pc_q[1];
            end
            if (enq) begin
                pc_d               = pc_q + addr_t'(1);
                q_instr_d[wr_slot] = bus.pm_data;
                q_pc_d[wr_slot]    = pc_q;
            end
            unique case ({enq, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            q_instr_q[0] <= '0;
            q_instr_q[1] <= '0;
            q_pc_q[0]    <= '0;
            q_pc_q[1]    <= '0;
            count_q      <= 2'd0;
            halted_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            q_instr_q <= q_instr_d;
            q_pc_q    <= q_pc_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.pm_addr     = pc_q;
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.instr       = bus.instr_valid ? q_instr_q[0] : 16'h0000;
    assign bus.instr_pc    = bus.instr_valid ? q_pc_q[0] : '0;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, backpressure, redirect, wrap,
// zero-word halt (both builds), and reset-over-redirect priority.
module tb_instruction_fetch;
    localparam int unsigned AW = 6;

    logic clk;
    logic rst;
    logic [15:0] mem [64];

    int n_total = 0;
    int n_bad   = 0;

    instruction_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    instruction_fetch #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.pm_data = mem[bus.pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head must hold word for pc (memory fill is 16'hA000 | pc).
    task automatic check_head(input string tag, input int pc);
        check_eq({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        check_eq({tag, ".pc"},    32'(bus.instr_pc),    32'(pc));
        check_eq({tag, ".instr"}, 32'(bus.instr),       32'(16'hA000 | pc));
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
        check_eq({tag, ".instr"}, 32'(bus.instr),       32'd0);
        check_eq({tag, ".pc"},    32'(bus.instr_pc),    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 | 16'(i);
        mem[40] = 16'h0000;

        rst               = 1'b1;
        bus.instr_ready   = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;

        // Reset state
        step();
        step();
        check_empty("rst");
        check_eq("rst.pm_addr", 32'(bus.pm_addr), 32'd0);
        check_eq("rst.halted",  32'(bus.halted),  32'd0);

        // 1: sequential fetch
        rst = 1'b0;
        step();
        check_head("seq0", 0);
        check_eq("seq0.pm_addr", 32'(bus.pm_addr), 32'd1);
        for (int p = 1; p <= 3; p++) begin
            step();
            check_head("seq", p);
        end
        check_eq("seq.pm_addr", 32'(bus.pm_addr), 32'd4);

        // 2: backpressure
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        step();
        check_head("bp0", 0);
        check_eq("bp0.pm_addr", 32'(bus.pm_addr), 32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            check_head("bp.hold", 0);
            check_eq("bp.pm_addr", 32'(bus.pm_addr), 32'd2);
        end
        bus.instr_ready = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            step();
            check_head("bp.drain", p);
        end
        check_eq("bp.pm_addr6", 32'(bus.pm_addr), 32'd6);

        // 3: redirect flush with queue {4,5} and a live handshake
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd30;
        step();
        bus.redirect = 1'b0;
        check_eq("rd.valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rd.pm_addr", 32'(bus.pm_addr), 32'd30);
        step();
        check_head("rd30", 30);
        step();
        check_head("rd31", 31);

        // 4: wrap-around
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd63;
        step();
        bus.redirect = 1'b0;
        check_eq("wrap.bubble", 32'(bus.instr_valid), 32'd0);
        step();
        check_head("wrap63", 63);
        step();
        check_head("wrap0", 0);
        step();
        check_head("wrap1", 1);

        // 5: zero word at 40
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd38;
        step();
        bus.redirect = 1'b0;
        step();
        check_head("z38", 38);
        step();
        check_head("z39", 39);
        step();
`ifdef FETCH_HALT_ON_ZERO_EN
        check_eq("z.valid",   32'(bus.instr_valid), 32'd0);
        check_eq("z.halted",  32'(bus.halted),      32'd1);
        check_eq("z.pm_addr", 32'(bus.pm_addr),     32'd40);
        step();
        check_eq("z.valid2",   32'(bus.instr_valid), 32'd0);
        check_eq("z.pm_addr2", 32'(bus.pm_addr),     32'd40);
`else
        check_eq("z.valid", 32'(bus.instr_valid), 32'd1);
        check_eq("z.pc40",  32'(bus.instr_pc),    32'd40);
        check_eq("z.instr", 32'(bus.instr),       32'd0);
        check_eq("z.halted", 32'(bus.halted),     32'd0);
        step();
        check_head("z41", 41);
        check_eq("z.halted2", 32'(bus.halted), 32'd0);
`endif
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd30;
        step();
        bus.redirect = 1'b0;
        check_eq("zr.halted", 32'(bus.halted),  32'd0);
        check_eq("zr.pm_addr", 32'(bus.pm_addr), 32'd30);
        step();
        check_head("zr30", 30);

        // 6: reset beats redirect on a full queue
        bus.instr_ready = 1'b0;
        step();
        check_eq("rp.pm_addr32", 32'(bus.pm_addr), 32'd32);
        check_head("rp.full", 30);
        rst               = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd10;
        step();
        check_empty("rp");
        check_eq("rp.pm_addr", 32'(bus.pm_addr), 32'd0);
        check_eq("rp.halted",  32'(bus.halted),  32'd0);
        rst             = 1'b0;
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        check_head("rp.restart", 0);
        check_eq("rp.pm_addr1", 32'(bus.pm_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
